// File: rtl/eth_pdu_segmenter.sv
// Slices gated byte bursts into PDUs held in a byte ring buffer, queues one
// descriptor per PDU and replays the head PDU to a byte-pulling transmitter.
module eth_pdu_segmenter #(
  parameter int PDU_MAX      = 1470,
  parameter int BUF_AW       = 13,
  parameter int DESC_AW      = 2,
  parameter int CH_W         = 2,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_data,
  input  logic              i_wr,
  input  logic              i_din,
  input  logic [CH_W-1:0]   i_ch,
  output logic              o_full,
  output logic              o_trig_send,
  output logic [10:0]       o_pdu_len,
  output logic [7:0]        o_pck_ident,
  output logic [7:0]        o_pck_idx,
  output logic [CH_W-1:0]   o_pck_ch,
  input  logic              i_get_byte,
  output logic [7:0]        o_byte,
  input  logic              i_send_over,
  output logic [15:0]       o_drop_cnt,
  output logic [DESC_AW:0]  o_desc_cnt
);
  localparam int DESC_DEPTH = 1 << DESC_AW;
  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [10:0]      LEN_MAX  = 11'(PDU_MAX);
  localparam logic [DESC_AW:0] CNT_FULL = (DESC_AW+1)'(DESC_DEPTH);
  localparam logic [TW-1:0]    TO_LAST  = TW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  if ((2 ** BUF_AW) < DESC_DEPTH * PDU_MAX) begin : g_buf_too_small
    $error("byte buffer cannot hold DESC_DEPTH full-size PDUs");
  end
  if (PDU_MAX < 1 || PDU_MAX > 2047) begin : g_pdu_max_range
    $error("PDU_MAX out of range 1..2047");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_POP} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [7:0]         buf_mem [2 ** BUF_AW];
  logic [BUF_AW-1:0]  d_start [DESC_DEPTH];
  logic [10:0]        d_len   [DESC_DEPTH];
  logic [7:0]         d_ident [DESC_DEPTH];
  logic [7:0]         d_idx   [DESC_DEPTH];
  logic [CH_W-1:0]    d_ch    [DESC_DEPTH];

  logic [BUF_AW-1:0]  wr_ptr, rd_ptr, seg_start, cur_start;
  logic [10:0]        seg_cnt, push_len;
  logic [CH_W-1:0]    seg_ch, cur_ch;
  logic [7:0]         ident, idx;
  logic               burst_active;
  logic [TW-1:0]      idle_tmr;
  logic [DESC_AW-1:0] dq_wr, dq_rd;
  logic [DESC_AW:0]   desc_cnt_nxt;
  logic [7:0]         byte_p1;
  logic               wren, first_byte, size_close, end_close, tmo_close, burst_end;
  logic               push, pop, load, rd_en;
  state_t             state, state_d;

  always_comb begin
    wren         = i_wr & i_din & ~o_full;
    first_byte   = (seg_cnt == 11'd0);
    cur_start    = first_byte ? wr_ptr : seg_start;
    cur_ch       = first_byte ? i_ch : seg_ch;
    size_close   = wren & (seg_cnt == LEN_MAX - 11'd1);
    burst_end    = ~i_wr & burst_active;
    end_close    = burst_end & ~first_byte;
    tmo_close    = (IDLE_TIMEOUT > 0) & i_wr & ~wren & ~first_byte & (idle_tmr == TO_LAST);
    push         = size_close | end_close | tmo_close;
    push_len     = size_close ? LEN_MAX : seg_cnt;
    pop          = (state == S_SEND) & i_send_over;
    load         = (state == S_LOAD);
    rd_en        = (state == S_SEND) & i_get_byte;
    desc_cnt_nxt = o_desc_cnt + {{DESC_AW{1'b0}}, push} - {{DESC_AW{1'b0}}, pop};
  end

  // Write side: segmentation control, descriptor occupancy and drop accounting
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      seg_cnt      <= '0;
      ident        <= '0;
      idx          <= '0;
      burst_active <= 1'b0;
      idle_tmr     <= '0;
      dq_wr        <= '0;
      o_desc_cnt   <= '0;
      o_full       <= 1'b0;
      o_drop_cnt   <= '0;
    end else begin
      if (wren) wr_ptr <= wr_ptr + 1'b1;
      if (push) seg_cnt <= '0;
      else if (wren) seg_cnt <= seg_cnt + 11'd1;
      if (push | wren | ~i_wr) idle_tmr <= '0;
      else if (!first_byte) idle_tmr <= idle_tmr + 1'b1;
      if (burst_end) begin
        ident <= ident + 8'd1;
        idx   <= '0;
      end else if (size_close | tmo_close) begin
        idx <= idx + 8'd1;
      end
      // a burst only counts once a byte has actually been accepted
      burst_active <= i_wr & (burst_active | wren);
      if (push) dq_wr <= dq_wr + 1'b1;
      o_desc_cnt <= desc_cnt_nxt;
      o_full     <= (desc_cnt_nxt == CNT_FULL);
      if (i_wr & i_din & o_full) o_drop_cnt <= sat_inc16(o_drop_cnt);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (o_desc_cnt != '0) state_d = S_LOAD;
      S_LOAD: state_d = S_SEND;
      S_SEND: if (i_send_over) state_d = S_POP;
      S_POP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read side: head descriptor presentation and byte pointer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      dq_rd       <= '0;
      rd_ptr      <= '0;
      o_trig_send <= 1'b0;
      o_pdu_len   <= '0;
      o_pck_ident <= '0;
      o_pck_idx   <= '0;
      o_pck_ch    <= '0;
    end else begin
      state       <= state_d;
      o_trig_send <= load;
      if (load) begin
        o_pdu_len   <= d_len[dq_rd];
        o_pck_ident <= d_ident[dq_rd];
        o_pck_idx   <= d_idx[dq_rd];
        o_pck_ch    <= d_ch[dq_rd];
        rd_ptr      <= d_start[dq_rd];
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // popping on i_send_over frees the slot one cycle later instead of two
      if (pop) dq_rd <= dq_rd + 1'b1;
    end
  end

  // Storage: byte ring, descriptor slots and registered read port
  always_ff @(posedge i_clk) begin
    if (wren) buf_mem[wr_ptr] <= i_data;
    if (wren & first_byte) begin
      seg_start <= wr_ptr;
      seg_ch    <= i_ch;
    end
    if (push) begin
      d_start[dq_wr] <= cur_start;
      d_len[dq_wr]   <= push_len;
      d_ident[dq_wr] <= ident;
      d_idx[dq_wr]   <= idx;
      d_ch[dq_wr]    <= cur_ch;
    end
    if (rd_en) byte_p1 <= buf_mem[rd_ptr];
  end

  assign o_byte = byte_p1;

endmodule

// File: tb/tb_eth_pdu_segmenter.sv
// Scoreboard bench for eth_pdu_segmenter: directed bursts push expected PDUs
// and bytes; a monitor checks every o_trig_send and every returned byte.
module tb_eth_pdu_segmenter;
  localparam int PDU_MAX      = 1470;
  localparam int BUF_AW       = 13;
  localparam int DESC_AW      = 2;
  localparam int CH_W         = 2;
  localparam int IDLE_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             i_rst_n, i_wr, i_din, i_get_byte, i_send_over;
  logic [7:0]       i_data;
  logic [CH_W-1:0]  i_ch;
  logic             o_full, o_trig_send;
  logic [10:0]      o_pdu_len;
  logic [7:0]       o_pck_ident, o_pck_idx, o_byte;
  logic [CH_W-1:0]  o_pck_ch;
  logic [15:0]      o_drop_cnt;
  logic [DESC_AW:0] o_desc_cnt;

  always #5 clk = ~clk;

  eth_pdu_segmenter #(
    .PDU_MAX(PDU_MAX), .BUF_AW(BUF_AW), .DESC_AW(DESC_AW),
    .CH_W(CH_W), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_wr(i_wr), .i_din(i_din),
    .i_ch(i_ch), .o_full(o_full), .o_trig_send(o_trig_send), .o_pdu_len(o_pdu_len),
    .o_pck_ident(o_pck_ident), .o_pck_idx(o_pck_idx), .o_pck_ch(o_pck_ch),
    .i_get_byte(i_get_byte), .o_byte(o_byte), .i_send_over(i_send_over),
    .o_drop_cnt(o_drop_cnt), .o_desc_cnt(o_desc_cnt)
  );

  typedef struct { int len; int ident; int idx; int ch; } desc_t;
  desc_t      exp_desc[$];
  logic [7:0] exp_bytes[$];
  int         errors = 0;
  int         checks = 0;
  bit         tx_en = 1'b0;
  int         seg = 0;
  int         dctr = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s", name, what);
  endtask

  task automatic exp_pdu(input int len, input int ident, input int idx, input int ch);
    exp_desc.push_back('{len, ident, idx, ch});
  endtask

  // ch0 is driven on the first byte of each PDU and its complement elsewhere
  task automatic write_bytes(input int n, input logic [CH_W-1:0] ch0,
                             input bit accepted, input bit readback, input bit din_gap);
    logic [CH_W-1:0] ch;
    logic [7:0]      b;
    ch = ch0;
    for (int i = 0; i < n; i++) begin
      b = 8'((dctr * 13) + (dctr >> 8) + 5);
      dctr++;
      if (din_gap) begin
        @(negedge clk);
        i_wr = 1'b1; i_din = 1'b0; i_ch = ~ch;
      end
      @(negedge clk);
      i_wr = 1'b1; i_din = 1'b1; i_data = b;
      i_ch = (seg == 0) ? ch : ~ch;
      if (accepted) begin
        if (readback) exp_bytes.push_back(b);
        seg++;
        if (seg == PDU_MAX) begin
          seg = 0;
          ch = ch + 1'b1;
        end
      end
    end
  endtask

  task automatic end_burst();
    @(negedge clk);
    i_wr = 1'b0; i_din = 1'b0;
    @(negedge clk);
    @(negedge clk);
    seg = 0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (n < 8000 && !(exp_desc.size() == 0 && exp_bytes.size() == 0 && o_desc_cnt == '0)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_desc_left"}, exp_desc.size(), 0);
    check({tag, "_bytes_left"}, exp_bytes.size(), 0);
    check({tag, "_desc_cnt"}, int'(o_desc_cnt), 0);
  endtask

  // Transmitter model: pulls every byte of the presented PDU, then releases it
  initial begin : tx
    bit busy;
    int rem;
    busy = 1'b0;
    rem = 0;
    i_get_byte = 1'b0;
    i_send_over = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_get_byte = 1'b0;
      i_send_over = 1'b0;
      if (!i_rst_n) begin
        busy = 1'b0;
      end else begin
        if (o_trig_send) begin
          busy = 1'b1;
          rem = int'(o_pdu_len);
        end
        if (busy && tx_en) begin
          if (rem > 0) begin
            i_get_byte = 1'b1;
            rem--;
          end else begin
            i_send_over = 1'b1;
            busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    bit         byte_due;
    desc_t      d;
    logic [7:0] eb;
    byte_due = 1'b0;
    forever begin
      @(negedge clk);
      if (!i_rst_n) begin
        byte_due = 1'b0;
      end else begin
        if (byte_due) begin
          if (exp_bytes.size() == 0) fail("o_byte_extra", "byte with none expected");
          else begin
            eb = exp_bytes.pop_front();
            check("o_byte", int'(o_byte), int'(eb));
          end
        end
        byte_due = i_get_byte;
        if (o_trig_send) begin
          if (exp_desc.size() == 0) fail("trig_unexpected", "o_trig_send with no PDU expected");
          else begin
            d = exp_desc.pop_front();
            check("pdu_len", int'(o_pdu_len), d.len);
            check("pck_ident", int'(o_pck_ident), d.ident);
            check("pck_idx", int'(o_pck_idx), d.idx);
            check("pck_ch", int'(o_pck_ch), d.ch);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    i_rst_n = 1'b0; i_wr = 1'b0; i_din = 1'b0; i_data = '0; i_ch = '0;
    repeat (4) @(negedge clk);
    check("rst_full", int'(o_full), 0);
    check("rst_trig", int'(o_trig_send), 0);
    check("rst_desc_cnt", int'(o_desc_cnt), 0);
    check("rst_drop_cnt", int'(o_drop_cnt), 0);
    check("rst_pdu_len", int'(o_pdu_len), 0);
    check("rst_ident", int'(o_pck_ident), 0);
    check("rst_idx", int'(o_pck_idx), 0);
    check("rst_ch", int'(o_pck_ch), 0);
    i_rst_n = 1'b1;

    // 3000-byte burst: two size closes then an end close
    tx_en = 1'b1;
    exp_pdu(1470, 0, 0, 1); exp_pdu(1470, 0, 1, 2); exp_pdu(60, 0, 2, 3);
    write_bytes(3000, 2'd1, 1'b1, 1'b1, 1'b0);
    end_burst();
    wait_drain("b3000");

    // exact multiple: burst end with empty segment still bumps ident
    exp_pdu(1470, 1, 0, 0); exp_pdu(1470, 1, 1, 1);
    write_bytes(2940, 2'd0, 1'b1, 1'b1, 1'b0);
    end_burst();
    exp_pdu(10, 2, 0, 2);
    write_bytes(10, 2'd2, 1'b1, 1'b1, 1'b1);
    end_burst();
    repeat (5) begin
      @(negedge clk);
      i_wr = 1'b1; i_din = 1'b0;
    end
    end_burst();
    exp_pdu(5, 3, 0, 3);
    write_bytes(5, 2'd3, 1'b1, 1'b1, 1'b0);
    end_burst();
    wait_drain("short");
    check("drop_none", int'(o_drop_cnt), 0);

    // idle timeout inside a burst splits the PDU, ident kept
    exp_pdu(100, 4, 0, 1); exp_pdu(50, 4, 1, 2);
    write_bytes(100, 2'd1, 1'b1, 1'b1, 1'b0);
    repeat (IDLE_TIMEOUT) begin
      @(negedge clk);
      i_wr = 1'b1; i_din = 1'b0;
    end
    seg = 0;
    write_bytes(50, 2'd2, 1'b1, 1'b1, 1'b0);
    end_burst();
    wait_drain("timeout");

    // stalled transmitter fills the descriptor queue
    tx_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_pdu(20, 5 + k, 0, k);
      write_bytes(20, CH_W'(k), 1'b1, 1'b1, 1'b0);
      end_burst();
    end
    check("full_after_4th", int'(o_full), 1);
    check("desc_cnt_full", int'(o_desc_cnt), 4);
    write_bytes(10, 2'd0, 1'b0, 1'b0, 1'b0);
    end_burst();
    check("drop_cnt_10", int'(o_drop_cnt), 10);
    check("full_held", int'(o_full), 1);
    check("desc_cnt_held", int'(o_desc_cnt), 4);
    tx_en = 1'b1;
    n = 0;
    while (!i_send_over && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("full_at_send_over", int'(o_full), 1);
    @(negedge clk);
    check("full_after_pop", int'(o_full), 0);
    check("desc_cnt_after_pop", int'(o_desc_cnt), 3);
    exp_pdu(8, 9, 0, 1);
    write_bytes(8, 2'd1, 1'b1, 1'b1, 1'b0);
    end_burst();
    wait_drain("stall");
    check("drop_cnt_kept", int'(o_drop_cnt), 10);

    // burst crossing the end of the byte ring
    exp_pdu(1470, 10, 0, 2); exp_pdu(1470, 10, 1, 3); exp_pdu(60, 10, 2, 0);
    write_bytes(3000, 2'd2, 1'b1, 1'b1, 1'b0);
    end_burst();
    wait_drain("wrap");

    // reset mid-burst with two PDUs queued and a partial one open
    tx_en = 1'b0;
    exp_pdu(1470, 11, 0, 1);
    write_bytes(2970, 2'd1, 1'b1, 1'b0, 1'b0);
    check("desc_cnt_pre_reset", int'(o_desc_cnt), 2);
    @(negedge clk);
    i_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_desc_cnt", int'(o_desc_cnt), 0);
    check("mid_rst_full", int'(o_full), 0);
    check("mid_rst_drop_cnt", int'(o_drop_cnt), 0);
    check("mid_rst_trig", int'(o_trig_send), 0);
    check("mid_rst_ident", int'(o_pck_ident), 0);
    i_wr = 1'b0; i_din = 1'b0;
    i_rst_n = 1'b1;
    seg = 0;
    repeat (30) @(negedge clk);
    check("desc_cnt_idle_after_reset", int'(o_desc_cnt), 0);
    tx_en = 1'b1;
    exp_pdu(7, 0, 0, 2);
    write_bytes(7, 2'd2, 1'b1, 1'b1, 1'b0);
    end_burst();
    wait_drain("post_reset");

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
